// File: rtl/lfsr_crc_stream_pkg.sv
// lfsr_crc_stream_pkg: CRC-32 defaults and keep-to-byte-count helper
package lfsr_crc_stream_pkg;
    localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
    localparam logic [31:0] CRC32_INIT    = 32'hffffffff;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hffffffff;
    localparam logic [31:0] CRC32_RESIDUE = 32'hdebb20e3;
    localparam int KEEP_MAX = 64;

    // Length of the run of ones starting at lane 0; lanes past the first zero never count.
    function automatic int keep_bytes(input logic [KEEP_MAX-1:0] keep, input int width);
        keep_bytes = 0;
        for (int i = 0; i < KEEP_MAX; i++)
            if (i < width && keep[i] && keep_bytes == i) keep_bytes++;
    endfunction
endpackage

// File: rtl/lfsr.sv
// lfsr: combinational CRC/LFSR update over DATA_WIDTH input bits
module lfsr #(
    parameter int LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 32'h04c11db7,
    parameter LFSR_CONFIG = "GALOIS",
    parameter bit REVERSE = 1'b1,
    parameter int DATA_WIDTH = 8,
    parameter STYLE = "AUTO"
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);
    if (LFSR_CONFIG != "GALOIS") $error("lfsr: only GALOIS CRC configuration is supported");
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") $error("lfsr: unknown STYLE");

    logic [LFSR_WIDTH-1:0] s;
    logic fb;
    // Work in normal (MSB-first) form; reflection only flips state and bit order.
    always_comb begin
        s = state_in;
        fb = 1'b0;
        state_out = '0;
        if (REVERSE) for (int j = 0; j < LFSR_WIDTH; j++) s[j] = state_in[LFSR_WIDTH-1-j];
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = s[LFSR_WIDTH-1] ^ (REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i]);
            s = {s[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
        end
        for (int j = 0; j < LFSR_WIDTH; j++) state_out[j] = REVERSE ? s[LFSR_WIDTH-1-j] : s[j];
    end
endmodule

// File: rtl/lfsr_crc_stream_keep_count.sv
// lfsr_crc_stream_keep_count: number of contiguous ones in keep from lane 0
module lfsr_crc_stream_keep_count
    import lfsr_crc_stream_pkg::*;
#(
    parameter int KEEP_WIDTH = 8,
    parameter int NW = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [NW-1:0]         n
);
    assign n = NW'(keep_bytes(KEEP_MAX'(keep), KEEP_WIDTH));
endmodule

// File: rtl/lfsr_crc_stream.sv
// lfsr_crc_stream: framed streaming CRC with keep/last input and valid/ready result
module lfsr_crc_stream
    import lfsr_crc_stream_pkg::*;
#(
    parameter int LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = CRC32_POLY,
    parameter LFSR_CONFIG = "GALOIS",
    parameter bit REVERSE = 1'b1,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT = CRC32_INIT,
    parameter logic [LFSR_WIDTH-1:0] XOR_OUT = CRC32_XOR_OUT,
    parameter int COUNT_WIDTH = 16,
    parameter STYLE = "AUTO"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic [KEEP_WIDTH-1:0]  s_keep,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    output logic [LFSR_WIDTH-1:0]  crc_out,
    output logic [COUNT_WIDTH-1:0] crc_count,
    output logic                   crc_valid,
    input  logic                   crc_ready
);
    localparam int NW = $clog2(KEEP_WIDTH + 1);
    localparam int SW = COUNT_WIDTH + NW;
    localparam logic [SW-1:0] CMAX = SW'({COUNT_WIDTH{1'b1}});

    logic [LFSR_WIDTH-1:0]  crc_state;
    logic [COUNT_WIDTH-1:0] byte_cnt, cnt_full, cnt_last;
    logic [SW-1:0]          sum_full, sum_last;
    logic [NW-1:0]          n;
    logic [LFSR_WIDTH-1:0]  st [KEEP_WIDTH+1];
    logic                   acc;

    lfsr_crc_stream_keep_count #(.KEEP_WIDTH(KEEP_WIDTH), .NW(NW)) u_keep (.keep(s_keep), .n(n));

    // st[k] is crc_state advanced by the first k bytes; st[KEEP_WIDTH] also serves full beats.
    assign st[0] = crc_state;
    for (genvar k = 1; k <= KEEP_WIDTH; k++) begin : g_lfsr
        lfsr #(
            .LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_CONFIG(LFSR_CONFIG),
            .REVERSE(REVERSE), .DATA_WIDTH(8 * k), .STYLE(STYLE)
        ) u_lfsr (.data_in(s_data[8*k-1:0]), .state_in(crc_state), .state_out(st[k]));
    end

    assign s_ready  = !crc_valid || crc_ready;
    assign acc      = s_valid && s_ready;
    assign sum_full = SW'(byte_cnt) + SW'(KEEP_WIDTH);
    assign sum_last = SW'(byte_cnt) + SW'(n);
    assign cnt_full = sum_full > CMAX ? '1 : sum_full[COUNT_WIDTH-1:0];
    assign cnt_last = sum_last > CMAX ? '1 : sum_last[COUNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_state <= LFSR_INIT;
            byte_cnt  <= '0;
            crc_out   <= '0;
            crc_count <= '0;
            crc_valid <= 1'b0;
        end else if (acc && s_last) begin
            crc_state <= LFSR_INIT;
            byte_cnt  <= '0;
            crc_out   <= st[n] ^ XOR_OUT;
            crc_count <= cnt_last;
            crc_valid <= 1'b1;
        end else begin
            if (acc) begin
                crc_state <= st[KEEP_WIDTH];
                byte_cnt  <= cnt_full;
            end
            if (crc_ready) crc_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lfsr_crc_stream.sv
// tb_lfsr_crc_stream: table-driven and directed checks of the framed CRC stream engine
module tb_lfsr_crc_stream;
    import lfsr_crc_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_data = '0;
    logic [7:0]  s_keep = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, crc_ready = 1'b1;
    logic        s_ready, crc_valid, s_ready2, crc_valid2;
    logic [31:0] crc_out, crc_out2;
    logic [15:0] crc_count;
    logic [3:0]  crc_count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_crc_stream dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
        .s_ready(s_ready), .s_last(s_last), .crc_out(crc_out), .crc_count(crc_count),
        .crc_valid(crc_valid), .crc_ready(crc_ready)
    );

    lfsr_crc_stream #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid),
        .s_ready(s_ready2), .s_last(s_last), .crc_out(crc_out2), .crc_count(crc_count2),
        .crc_valid(crc_valid2), .crc_ready(crc_ready)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        ev;
        logic [31:0] eo;
        logic [15:0] ec;
    } vec_t;

    vec_t tab [8];
    logic [7:0] b [32];

    // Plain byte-serial reflected CRC-32 reference.
    function automatic logic [31:0] crc_ref(input logic [7:0] m [32], input int len);
        logic [31:0] c = 32'hffffffff;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, m[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
        end
        return ~c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) b[i] = 8'h0;
        tab[0] = '{64'h3837363534333231, 8'hff, 1'b0, 1'b0, 32'h0, 16'd0};
        tab[1] = '{64'h39, 8'h01, 1'b1, 1'b1, 32'hcbf43926, 16'd9};
        tab[2] = '{64'h00, 8'h01, 1'b1, 1'b1, 32'hd202ef8d, 16'd1};
        tab[3] = '{64'h00, 8'h00, 1'b1, 1'b1, 32'h00000000, 16'd0};
        tab[4] = '{64'h3837363534333231, 8'hff, 1'b0, 1'b0, 32'h0, 16'd0};
        tab[5] = '{64'h000000cbf4392639, 8'h1f, 1'b1, 1'b1, CRC32_RESIDUE ^ CRC32_XOR_OUT, 16'd13};
        b[0] = 8'h39; b[1] = 8'ha5;
        tab[6] = '{64'h77_5a_a5_39, 8'h0b, 1'b1, 1'b1, crc_ref(b, 2), 16'd2};
        for (int i = 0; i < 8; i++) b[i] = 8'h31 + 8'(i);
        tab[7] = '{64'h3837363534333231, 8'hff, 1'b1, 1'b1, crc_ref(b, 8), 16'd8};

        idle(); idle();
        rst = 1'b0;
        chk("reset_valid", {63'h0, crc_valid}, 64'h0);
        chk("reset_out", {32'h0, crc_out}, 64'h0);
        chk("reset_count", {48'h0, crc_count}, 64'h0);
        chk("reset_ready", {63'h0, s_ready}, 64'h1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec%0d_s_ready", i), {63'h0, s_ready}, 64'h1);
            beat(tab[i].data, tab[i].keep, tab[i].last);
            chk($sformatf("vec%0d_valid", i), {63'h0, crc_valid}, {63'h0, tab[i].ev});
            if (tab[i].ev) begin
                chk($sformatf("vec%0d_out", i), {32'h0, crc_out}, {32'h0, tab[i].eo});
                chk($sformatf("vec%0d_count", i), {48'h0, crc_count}, {48'h0, tab[i].ec});
            end
        end

        idle();
        chk("drain_valid", {63'h0, crc_valid}, 64'h0);
        crc_ready = 1'b0;
        beat(64'h3837363534333231, 8'hff, 1'b0);
        beat(64'h39, 8'h01, 1'b1);
        chk("bp_out", {32'h0, crc_out}, 64'hcbf43926);
        s_data = 64'h0; s_keep = 8'h01; s_last = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_s_ready", i), {63'h0, s_ready}, 64'h0);
            chk($sformatf("bp%0d_valid", i), {63'h0, crc_valid}, 64'h1);
            chk($sformatf("bp%0d_out", i), {32'h0, crc_out}, 64'hcbf43926);
            chk($sformatf("bp%0d_count", i), {48'h0, crc_count}, 64'd9);
            @(posedge clk); #1;
        end
        crc_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", {63'h0, s_ready}, 64'h1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("bp_refill_valid", {63'h0, crc_valid}, 64'h1);
        chk("bp_refill_out", {32'h0, crc_out}, 64'hd202ef8d);
        chk("bp_refill_count", {48'h0, crc_count}, 64'd1);
        idle();
        chk("bp_drain_valid", {63'h0, crc_valid}, 64'h0);

        beat(64'h34333231, 8'hff, 1'b0);
        rst = 1'b1; idle(); rst = 1'b0;
        crc_ready = 1'b0;
        beat(64'h3837363534333231, 8'hff, 1'b0);
        beat(64'h39, 8'h01, 1'b1);
        chk("rst_mid_out", {32'h0, crc_out}, 64'hcbf43926);
        chk("rst_mid_count", {48'h0, crc_count}, 64'd9);
        rst = 1'b1; idle(); rst = 1'b0;
        chk("rst_drop_valid", {63'h0, crc_valid}, 64'h0);
        chk("rst_drop_out", {32'h0, crc_out}, 64'h0);
        crc_ready = 1'b1;

        for (int i = 0; i < 24; i++) b[i] = 8'(i * 7 + 1);
        for (int k = 0; k < 3; k++)
            beat({b[8*k+7], b[8*k+6], b[8*k+5], b[8*k+4], b[8*k+3], b[8*k+2], b[8*k+1], b[8*k]},
                 8'hff, k == 2);
        chk("sat_valid", {63'h0, crc_valid2}, 64'h1);
        chk("sat_count", {60'h0, crc_count2}, 64'hf);
        chk("sat_out", {32'h0, crc_out2}, {32'h0, crc_ref(b, 24)});
        chk("wide_count", {48'h0, crc_count}, 64'd24);
        chk("wide_out", {32'h0, crc_out}, {32'h0, crc_ref(b, 24)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lfsr_crc_stream.md
Name: lfsr_crc_stream

Overview:
- Streaming, framed CRC engine built on the combinational lfsr block.
- Accepts a DATA_WIDTH-wide beat stream with byte keep and last markers, and accumulates CRC state across beats.
- On the last beat it applies the final XOR and presents the result with a valid/ready handshake and the frame byte count.
- Sits between a MAC/packet datapath and the FCS checker/inserter. Defaults give Ethernet CRC-32.

Parameters:
- LFSR_WIDTH, 32, CRC width
- LFSR_POLY, 32'h04c11db7, generator polynomial (normal form, implicit MSB)
- LFSR_CONFIG, "GALOIS", passed to lfsr instances
- REVERSE, 1, bit-reflected data and state (LSB first)
- DATA_WIDTH, 64, beat width in bits; must be a multiple of 8
- KEEP_WIDTH, DATA_WIDTH/8, byte lanes
- LFSR_INIT, 32'hffffffff, state at frame start
- XOR_OUT, 32'hffffffff, final XOR applied to the result
- COUNT_WIDTH, 16, frame byte counter width
- STYLE, "AUTO", passed to lfsr instances

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  DATA_WIDTH  beat data; byte 0 (bits 7:0) is first on the wire
- s_keep  in  KEEP_WIDTH  byte enables; only examined when s_last=1
- s_valid  in  1  beat valid
- s_ready  out  1  beat accept
- s_last  in  1  final beat of frame
- crc_out  out  LFSR_WIDTH  final CRC (state ^ XOR_OUT)
- crc_count  out  COUNT_WIDTH  bytes in frame, saturating
- crc_valid  out  1  result valid
- crc_ready  in  1  result accept

Behaviour:
- Beat accepted when s_valid && s_ready.
- s_ready = !crc_valid || crc_ready, combinational. A result slot is freed and refilled in the same cycle.
- Registered state: crc_state[LFSR_WIDTH], byte_cnt[COUNT_WIDTH], out regs crc_out/crc_count/crc_valid.
- Reset values: crc_state=LFSR_INIT, byte_cnt=0, crc_out=0, crc_count=0, crc_valid=0.
- Non-last accepted beat:
  - crc_state <= lfsr(full DATA_WIDTH, s_data, crc_state).
  - byte_cnt += KEEP_WIDTH.
  - s_keep is ignored (full beat).
- Last accepted beat, with n = number of contiguous ones in s_keep starting at bit 0 (0..KEEP_WIDTH):
  - Bits above the first zero are ignored.
  - next = n==0 ? crc_state : lfsr_n(s_data[8n-1:0], crc_state).
  - crc_out <= next ^ XOR_OUT.
  - crc_count <= sat(byte_cnt + n).
  - crc_valid <= 1.
  - crc_state <= LFSR_INIT; byte_cnt <= 0.
- Latency: result visible the cycle after the last beat is accepted.
- Result register: crc_valid clears when crc_ready=1 and no new last beat is accepted that cycle. crc_out and crc_count stay stable while crc_valid && !crc_ready.
- Simultaneous crc_ready handshake and new last beat: crc_valid stays 1 and the new result is loaded. Back-to-back single-beat frames run at one result per cycle.
- Saturation: byte_cnt and crc_count hold at 2^COUNT_WIDTH-1 and never wrap. The CRC is still computed correctly.
- Reset mid-frame: the partial state is discarded, and any pending result is dropped (crc_valid=0).
- No reset term on data-path-only registers beyond those listed above.

Decomposition:
- Shared package/header: default CRC-32 constants (POLY 32'h04c11db7, INIT/XOR_OUT 32'hffffffff, residue 32'hdebb20e3) and a keep-to-byte-count function.
- Sub-modules: KEEP_WIDTH instances of lfsr, generated, instance k at DATA_WIDTH=8k, fed the same crc_state. The full-width instance is shared with the non-last path.
- One small sub-module, lfsr_crc_stream_keep_count: contiguous-ones counter.

Test Plan:
1. Defaults. Beat0 s_data="12345678" (bytes 0x31..0x38, LSB first), keep 0xff, last 0. Beat1 0x39, keep 0x01, last 1 -> next cycle crc_valid=1, crc_out=0xcbf43926, crc_count=9.
2. Single beat 0x00, keep 0x01, last -> crc_out=0xd202ef8d, crc_count=1. Single beat, keep 0x00, last -> crc_out=0x00000000, crc_count=0.
3. Backpressure. crc_ready=0 for 3 cycles after test 1's result -> s_ready=0, crc_out holds 0xcbf43926. crc_ready=1 with a new last beat presented that cycle -> accepted, new result next cycle, crc_valid never drops.
4. Reset mid-frame. Send "1234" as a full beat, pulse rst, then send test 1 -> crc_out=0xcbf43926, crc_count=9 (no carry-over).
5. Non-contiguous keep 0x0b on last beat with "9" in byte 0 -> treated as n=2, i.e. bytes 0–1 processed. Compare against the reference model.
6. COUNT_WIDTH=4 with a 3-beat frame (24 bytes) -> crc_count=15 (saturated), crc_out matches the model.
